// File: rtl/mtr_drv_ctrl.sv
// -----------------------------------------------------------------------------
// mtr_drv_ctrl
// Sequences the left/right PWM11 motor channels of the segway drive. Signed
// speed commands become 11-bit duty values plus direction bits. Duty and
// direction change only on the last cycle of each 2048-clock PWM period.
// Duty slews by at most SLEW per period, and a direction reversal always
// ramps through zero duty first.
//
// Ports
//   clk        in   1   system clock
//   rst_n      in   1   asynchronous active-low reset
//   en         in   1   drive enable
//   kill       in   1   fault stop, level sensitive
//   lft_spd    in  12   signed left speed command
//   rght_spd   in  12   signed right speed command
//   lft_duty   out 11   duty to left PWM11
//   rght_duty  out 11   duty to right PWM11
//   lft_fwd    out  1   left direction, 1 = forward
//   rght_fwd   out  1   right direction, 1 = forward
//   prd_end    out  1   high on the last cycle of each PWM period
//   drv_state  out  2   0 = IDLE, 1 = RUN, 2 = STOP, 3 = FAULT
// -----------------------------------------------------------------------------
module mtr_drv_ctrl #(
  parameter logic [10:0] SLEW     = 11'd64,
  parameter logic [10:0] MIN_DUTY = 11'd40,
  parameter logic [10:0] MAX_DUTY = 11'd2000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        kill,
  input  logic [11:0] lft_spd,
  input  logic [11:0] rght_spd,
  output logic [10:0] lft_duty,
  output logic [10:0] rght_duty,
  output logic        lft_fwd,
  output logic        rght_fwd,
  output logic        prd_end,
  output logic [1:0]  drv_state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STOP  = 2'd2,
    ST_FAULT = 2'd3
  } drv_state_e;

  drv_state_e  state_q;
  logic [10:0] prd_cnt_q;
  logic        prd_end_q;
  logic [10:0] lft_duty_q;
  logic [10:0] rght_duty_q;
  logic        lft_fwd_q;
  logic        rght_fwd_q;

  // Candidate {fwd, duty} for each channel if this cycle is an update edge.
  logic [11:0] lft_upd_s;
  logic [11:0] rght_upd_s;

  // Magnitude-to-duty mapping: zero stays zero, otherwise add the stiction
  // offset and clamp. -2048 has no positive twin, so it saturates to 2047.
  function automatic logic [10:0] spd_to_tgt(input logic [11:0] spd);
    logic [11:0] mag;
    logic [11:0] sum;
    if (spd[11]) begin
      mag = (~spd) + 12'd1;
    end else begin
      mag = spd;
    end
    if (mag[11]) begin
      mag = 12'd2047;
    end else begin
      mag = mag;
    end
    sum = mag + {1'b0, MIN_DUTY};
    if (mag == 12'd0) begin
      return 11'd0;
    end else if (sum > {1'b0, MAX_DUTY}) begin
      return MAX_DUTY;
    end else begin
      return sum[10:0];
    end
  endfunction

  // One bounded step from cur toward tgt, never overshooting either way.
  function automatic logic [10:0] slew_step(input logic [10:0] cur,
                                            input logic [10:0] tgt);
    logic [11:0] up;
    up = {1'b0, cur} + {1'b0, SLEW};
    if (cur < tgt) begin
      return (up > {1'b0, tgt}) ? tgt : up[10:0];
    end else if (cur > tgt) begin
      return ((cur - tgt) > SLEW) ? (cur - SLEW) : tgt;
    end else begin
      return cur;
    end
  endfunction

  // Next {fwd, duty} for one channel. With run=0 the target is zero and the
  // direction is held. A requested reversal first drives duty to zero; the
  // direction bit flips only on an update that starts at zero duty, so duty
  // in the new direction appears on the update after the flip at the earliest.
  function automatic logic [11:0] chan_next(input logic [10:0] cur,
                                            input logic        fwd,
                                            input logic [11:0] spd,
                                            input logic        run);
    logic tgt_fwd;
    tgt_fwd = ~spd[11];
    if (!run) begin
      return {fwd, slew_step(cur, 11'd0)};
    end else if (tgt_fwd != fwd) begin
      if (cur == 11'd0) begin
        return {tgt_fwd, 11'd0};
      end else begin
        return {fwd, slew_step(cur, 11'd0)};
      end
    end else begin
      return {fwd, slew_step(cur, spd_to_tgt(spd))};
    end
  endfunction

  // Enable selects commanded targets; without it both channels ramp to zero.
  assign lft_upd_s  = chan_next(lft_duty_q,  lft_fwd_q,  lft_spd,  en);
  assign rght_upd_s = chan_next(rght_duty_q, rght_fwd_q, rght_spd, en);

  // Period counter, drive FSM and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      prd_cnt_q   <= 11'd0;
      prd_end_q   <= 1'b0;
      lft_duty_q  <= 11'd0;
      rght_duty_q <= 11'd0;
      lft_fwd_q   <= 1'b1;
      rght_fwd_q  <= 1'b1;
    end else begin
      prd_cnt_q <= prd_cnt_q + 11'd1;
      // Registered one cycle early so prd_end is high exactly while the
      // count reads 2047.
      prd_end_q <= (prd_cnt_q == 11'd2046);
      if (kill) begin
        state_q     <= ST_FAULT;
        lft_duty_q  <= 11'd0;
        rght_duty_q <= 11'd0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            state_q <= en ? ST_RUN : ST_IDLE;
          end
          ST_RUN, ST_STOP: begin
            if (prd_end_q) begin
              lft_duty_q  <= lft_upd_s[10:0];
              lft_fwd_q   <= lft_upd_s[11];
              rght_duty_q <= rght_upd_s[10:0];
              rght_fwd_q  <= rght_upd_s[11];
            end else begin
              lft_duty_q  <= lft_duty_q;
              rght_duty_q <= rght_duty_q;
            end
            if (en) begin
              state_q <= ST_RUN;
            end else if ((state_q == ST_STOP) && prd_end_q &&
                         (lft_upd_s[10:0] == 11'd0) &&
                         (rght_upd_s[10:0] == 11'd0)) begin
              state_q <= ST_IDLE;
            end else begin
              state_q <= ST_STOP;
            end
          end
          ST_FAULT: begin
            state_q <= en ? ST_FAULT : ST_IDLE;
          end
          default: begin
            state_q     <= ST_FAULT;
            lft_duty_q  <= 11'd0;
            rght_duty_q <= 11'd0;
          end
        endcase
      end
    end
  end

  assign lft_duty  = lft_duty_q;
  assign rght_duty = rght_duty_q;
  assign lft_fwd   = lft_fwd_q;
  assign rght_fwd  = rght_fwd_q;
  assign prd_end   = prd_end_q;
  assign drv_state = state_q;

endmodule

// File: tb/tb_mtr_drv_ctrl.sv
module tb_mtr_drv_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        kill = 1'b0;
  logic [11:0] lft_spd = 12'd0;
  logic [11:0] rght_spd = 12'd0;
  logic [10:0] lft_duty, rght_duty;
  logic        lft_fwd, rght_fwd, prd_end;
  logic [1:0]  drv_state;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state (plain integers).
  int m_cnt, m_pe, m_state;
  int m_duty [2];
  int m_fwd  [2];

  mtr_drv_ctrl dut (
    .clk(clk), .rst_n(rst_n), .en(en), .kill(kill),
    .lft_spd(lft_spd), .rght_spd(rght_spd),
    .lft_duty(lft_duty), .rght_duty(rght_duty),
    .lft_fwd(lft_fwd), .rght_fwd(rght_fwd),
    .prd_end(prd_end), .drv_state(drv_state)
  );

  always #10 clk = ~clk;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void m_reset();
    m_cnt = 0; m_pe = 0; m_state = 0;
    m_duty[0] = 0; m_duty[1] = 0;
    m_fwd[0] = 1;  m_fwd[1] = 1;
  endfunction

  // One period-end update of a channel, from the rules in plain arithmetic.
  function automatic void ch_upd(input int s, input bit run, input int d0,
                                 input int f0, output int d1, output int f1);
    int goal, mag, want;
    f1 = f0;
    goal = 0;
    if (run) begin
      want = (s >= 0) ? 1 : 0;
      mag  = (s < 0) ? -s : s;
      if (mag > 2047) mag = 2047;
      goal = (mag == 0) ? 0 : ((mag + 40 > 2000) ? 2000 : mag + 40);
      if (want != f0) begin
        goal = 0;
        if (d0 == 0) f1 = want;
      end
    end
    if (d0 < goal) d1 = (d0 + 64 < goal) ? d0 + 64 : goal;
    else           d1 = (d0 - 64 > goal) ? d0 - 64 : goal;
  endfunction

  function automatic void m_step();
    int pe_now, nd, nf;
    int spd [2];
    if (!rst_n) begin
      m_reset();
      return;
    end
    spd[0] = int'($signed(lft_spd));
    spd[1] = int'($signed(rght_spd));
    pe_now = m_pe;
    m_pe   = (m_cnt == 2046) ? 1 : 0;
    m_cnt  = (m_cnt + 1) % 2048;
    if (kill) begin
      m_state = 3; m_duty[0] = 0; m_duty[1] = 0;
    end else if (m_state == 0) begin
      if (en) m_state = 1;
    end else if (m_state == 3) begin
      if (!en) m_state = 0;
    end else begin
      if (pe_now != 0) begin
        for (int c = 0; c < 2; c++) begin
          ch_upd(spd[c], en, m_duty[c], m_fwd[c], nd, nf);
          m_duty[c] = nd; m_fwd[c] = nf;
        end
      end
      if (en) m_state = 1;
      else if (m_state == 2 && pe_now != 0 && m_duty[0] == 0 && m_duty[1] == 0)
        m_state = 0;
      else m_state = 2;
    end
  endfunction

  task automatic compare_all();
    check_val("lft_duty",  int'(lft_duty),  m_duty[0]);
    check_val("rght_duty", int'(rght_duty), m_duty[1]);
    check_val("lft_fwd",   int'(lft_fwd),   m_fwd[0]);
    check_val("rght_fwd",  int'(rght_fwd),  m_fwd[1]);
    check_val("prd_end",   int'(prd_end),   m_pe);
    check_val("drv_state", int'(drv_state), m_state);
  endtask

  // Advance one clock, update the model and compare on the falling edge.
  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      m_step();
      @(negedge clk);
      compare_all();
    end
  endtask

  initial begin
    int r;
    m_reset();
    cyc(3);
    compare_all();
    rst_n = 1'b1;

    // Forward ramp from rest to 540 and hold.
    en = 1'b1;
    lft_spd = 12'd500;
    rght_spd = 12'($urandom_range(0, 2047));
    cyc(10 * 2048);
    check_val("t1_hold_540", int'(lft_duty), 540);

    // Reverse through zero; new direction duty on the update after the flip.
    lft_spd = 12'hE0C;  // -500
    rght_spd = 12'h800; // -2048
    cyc(11 * 2048);
    check_val("t2_rev_duty", int'(lft_duty), 64);
    check_val("t2_rev_fwd",  int'(lft_fwd), 0);

    // Kill landing on a prd_end cycle, then the re-enable handshake.
    for (int i = 0; i < 2100 && m_pe == 0; i++) cyc(1);
    kill = 1'b1;
    cyc(1);
    check_val("t5_fault_st", int'(drv_state), 3);
    check_val("t5_fault_dl", int'(lft_duty), 0);
    kill = 1'b0;
    cyc(5);
    check_val("t5_stay_fault", int'(drv_state), 3);
    en = 1'b0;
    cyc(1);
    check_val("t5_to_idle", int'(drv_state), 0);

    // Saturation extremes, then random speeds, enable toggles and kills.
    en = 1'b1;
    lft_spd = 12'h800;
    rght_spd = 12'h7FF;
    cyc(37 + $urandom_range(0, 100));
    for (int i = 0; i < 10 * 2048; i++) begin
      r = $urandom_range(0, 4095);
      if (i > 4 * 2048) begin
        if (r < 2) begin
          lft_spd = 12'($urandom);
          rght_spd = 12'($urandom);
        end else if (r == 2) en = ~en;
        else if (r == 3) kill = 1'b1;
        else if (kill && r < 400) kill = 1'b0;
      end
      cyc(1);
    end
    check_val("t3_sat_seen", 1, 1 - ((lft_duty > 11'd2000 || rght_duty > 11'd2000) ? 1 : 0));

    // Disable: ramp down to IDLE.
    kill = 1'b0;
    en = 1'b0;
    cyc(5 * 2048);

    // Async reset mid-ramp.
    en = 1'b1;
    lft_spd = 12'($urandom_range(100, 2047));
    rght_spd = 12'($urandom_range(100, 2047));
    cyc(3 * 2048 + 700);
    rst_n = 1'b0;
    #1;
    m_reset();
    compare_all();
    cyc(3);
    rst_n = 1'b1;
    cyc(2 * 2048);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
